// File: rtl/clock_display_scan_if.sv
// Signal bundle between the clock counter and the multiplexed seven-segment scanner.
// The master drives the time fields; the slave (scanner) drives segments and anodes.
interface clock_display_scan_if;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [1:0] adj_mode;
  logic       chime;
  logic [7:0] seg;
  logic [7:0] an;

  modport master (
    output hours, minutes, seconds, adj_mode, chime,
    input  seg, an
  );

  modport slave (
    input  hours, minutes, seconds, adj_mode, chime,
    output seg, an
  );
endinterface

// File: rtl/clock_display_scan.sv
// Eight-digit HH-MM-SS common-anode scanner with per-frame input snapshots,
// blinking of the field under adjustment and blinking separators during the chime.
module clock_display_scan #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_display_scan_if.slave    bus
);
  localparam int SCAN_DIV   = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W     = $clog2(SCAN_DIV);
  localparam int BLK_W      = $clog2(BLINK_HALF);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_HALF - 1);
  localparam logic [6:0]        GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0]        GLYPH_BLANK = 7'b1111111;

  logic [SCAN_W-1:0] scan_cnt_r;
  logic [BLK_W-1:0]  blk_cnt_r;
  logic [2:0]        idx_r;
  logic              blink_on_r;
  logic [7:0]        snap_h_r, snap_m_r, snap_s_r;
  logic [1:0]        snap_mode_r;
  logic              snap_chime_r;
  logic [7:0]        seg_r, an_r;
  logic              scan_tick_s;
  logic              hour_blank_s, min_blank_s, dash_blank_s;
  logic [6:0]        glyph_s;
  logic              blank_s;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  // Values of 100 and above cannot be shown as two decimal digits, so they render as dashes.
  function automatic logic [6:0] field_glyph(input logic [7:0] v, input logic tens);
    logic [3:0] q;
    logic [3:0] r;
    q = 4'(v / 8'd10);
    r = 4'(v % 8'd10);
    if (v >= 8'd100) begin
      return GLYPH_DASH;
    end else if (tens) begin
      return glyph(q);
    end else begin
      return glyph(r);
    end
  endfunction

  assign scan_tick_s = (scan_cnt_r == SCAN_LAST);

  // Digit prescaler and scan index, counting down from the leftmost digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 3'd7;
    end else if (scan_tick_s) begin
      scan_cnt_r <= '0;
      idx_r      <= idx_r - 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
    end
  end

  // Free-running blink phase, deliberately not aligned to the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_r  <= '0;
      blink_on_r <= 1'b1;
    end else if (blk_cnt_r == BLK_LAST) begin
      blk_cnt_r  <= '0;
      blink_on_r <= ~blink_on_r;
    end else begin
      blk_cnt_r  <= blk_cnt_r + {{(BLK_W-1){1'b0}}, 1'b1};
    end
  end

  // Sample all inputs once per frame so a frame never mixes old and new time.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_h_r     <= 8'd0;
      snap_m_r     <= 8'd0;
      snap_s_r     <= 8'd0;
      snap_mode_r  <= 2'd0;
      snap_chime_r <= 1'b0;
    end else if (scan_tick_s && (idx_r == 3'd0)) begin
      snap_h_r     <= bus.hours;
      snap_m_r     <= bus.minutes;
      snap_s_r     <= bus.seconds;
      snap_mode_r  <= bus.adj_mode;
      snap_chime_r <= bus.chime;
    end else begin
      snap_h_r     <= snap_h_r;
      snap_m_r     <= snap_m_r;
      snap_s_r     <= snap_s_r;
      snap_mode_r  <= snap_mode_r;
      snap_chime_r <= snap_chime_r;
    end
  end

  assign hour_blank_s = (snap_mode_r == 2'd1) && !blink_on_r;
  assign min_blank_s  = (snap_mode_r == 2'd2) && !blink_on_r;
  assign dash_blank_s = snap_chime_r && !blink_on_r;

  // Glyph and blanking for the digit currently selected by the scan index.
  always_comb begin
    glyph_s = GLYPH_BLANK;
    blank_s = 1'b0;
    case (idx_r)
      3'd7: begin glyph_s = field_glyph(snap_h_r, 1'b1); blank_s = hour_blank_s; end
      3'd6: begin glyph_s = field_glyph(snap_h_r, 1'b0); blank_s = hour_blank_s; end
      3'd5: begin glyph_s = GLYPH_DASH;                  blank_s = dash_blank_s; end
      3'd4: begin glyph_s = field_glyph(snap_m_r, 1'b1); blank_s = min_blank_s;  end
      3'd3: begin glyph_s = field_glyph(snap_m_r, 1'b0); blank_s = min_blank_s;  end
      3'd2: begin glyph_s = GLYPH_DASH;                  blank_s = dash_blank_s; end
      3'd1: begin glyph_s = field_glyph(snap_s_r, 1'b1); blank_s = 1'b0;         end
      3'd0: begin glyph_s = field_glyph(snap_s_r, 1'b0); blank_s = 1'b0;         end
      default: begin glyph_s = GLYPH_BLANK;              blank_s = 1'b1;         end
    endcase
  end

  // Segments and anode update together so no digit ever shows a neighbour's pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= 8'hFF;
      an_r  <= 8'hFF;
    end else begin
      seg_r <= blank_s ? 8'hFF : {1'b1, glyph_s};
      an_r  <= ~(8'd1 << idx_r);
    end
  end

  assign bus.seg = seg_r;
  assign bus.an  = an_r;
endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench: directed reset/frame/anti-tear steps plus randomized inputs,
// checked every cycle against a cycle-count based model of the display.
module tb_clock_display_scan;
  localparam int FRAME = 64;
  localparam int DWELL = 8;
  localparam int HALF  = 40;

  logic clk;
  logic rst;
  clock_display_scan_if bus ();

  clock_display_scan #(.CLK_FREQ(80), .SCAN_HZ(10), .BLINK_HZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int ecount = 0;
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0, m_chime = 0;
  logic [7:0] exp_seg, exp_an;
  logic [6:0] glyph_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, ecount);
  endtask

  function automatic logic [6:0] digit_of(input int v, input bit tens);
    if (v >= 100) return 7'b0111111;
    return tens ? glyph_tab[v / 10] : glyph_tab[v % 10];
  endfunction

  // Expected outputs after an edge, from the number of edges n that preceded it.
  task automatic model(input int n);
    int pos;
    bit blink;
    bit blank;
    logic [6:0] g;
    pos   = (n / DWELL) % 8;
    blink = ((n / HALF) % 2) == 0;
    blank = 1'b0;
    case (pos)
      0: begin g = digit_of(m_h, 1); blank = (m_mode == 1) && !blink; end
      1: begin g = digit_of(m_h, 0); blank = (m_mode == 1) && !blink; end
      2: begin g = 7'b0111111;       blank = (m_chime == 1) && !blink; end
      3: begin g = digit_of(m_m, 1); blank = (m_mode == 2) && !blink; end
      4: begin g = digit_of(m_m, 0); blank = (m_mode == 2) && !blink; end
      5: begin g = 7'b0111111;       blank = (m_chime == 1) && !blink; end
      6: g = digit_of(m_s, 1);
      default: g = digit_of(m_s, 0);
    endcase
    exp_an  = 8'hFF;
    exp_an[7 - pos] = 1'b0;
    exp_seg = blank ? 8'hFF : {1'b1, g};
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      ecount = 0;
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_chime = 0;
      exp_seg = 8'hFF;
      exp_an  = 8'hFF;
    end else begin
      model(ecount);
      ecount++;
      if (ecount % FRAME == 0) begin
        m_h = bus.hours; m_m = bus.minutes; m_s = bus.seconds;
        m_mode = bus.adj_mode; m_chime = bus.chime;
      end
    end
    #1;
    check("seg", bus.seg, exp_seg);
    check("an", bus.an, exp_an);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic to_frame_start();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (ecount % FRAME == 0) break;
      step();
    end
  endtask

  logic [7:0] frame_an  [0:7] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] frame_seg [0:7] = '{8'hA4, 8'hB0, 8'hBF, 8'h92, 8'h90, 8'hBF, 8'h99, 8'h80};

  initial begin
    rst = 1'b1;
    bus.hours = 8'd0; bus.minutes = 8'd0; bus.seconds = 8'd0;
    bus.adj_mode = 2'd0; bus.chime = 1'b0;
    steps(3);
    check("reset_seg", bus.seg, 8'hFF);
    check("reset_an", bus.an, 8'hFF);
    rst = 1'b0;
    step();
    check("first_an", bus.an, 8'h7F);
    check("first_seg", bus.seg, 8'hC0);
    steps(8);
    check("second_an", bus.an, 8'hBF);

    // Normal frame 23:59:48 with fixed expected glyphs.
    bus.hours = 8'd23; bus.minutes = 8'd59; bus.seconds = 8'd48;
    steps(1);
    to_frame_start();
    for (int d = 0; d < 8; d++) begin
      step();
      check("frame_an", bus.an, frame_an[d]);
      check("frame_seg", bus.seg, frame_seg[d]);
      steps(DWELL - 1);
    end

    // Anti-tear: minutes change mid-frame only appear next frame.
    bus.minutes = 8'd12;
    steps(1);
    to_frame_start();
    steps(2 * DWELL + 1);
    check("tear_an", bus.an, 8'hDF);
    bus.minutes = 8'd34;
    steps(DWELL);
    check("tear_m_old", bus.seg, 8'hF9);
    to_frame_start();
    steps(3 * DWELL + 1);
    check("tear_m_new", bus.seg, 8'hB0);

    // Hour adjust, minute adjust, chime, out-of-range, mode 3.
    bus.adj_mode = 2'd1; steps(2 * FRAME + 16);
    bus.adj_mode = 2'd2; steps(2 * FRAME + 16);
    bus.adj_mode = 2'd0; bus.chime = 1'b1; steps(2 * FRAME + 16);
    bus.chime = 1'b0; bus.hours = 8'd150; bus.adj_mode = 2'd3; steps(2 * FRAME + 16);

    // Randomized fields, modes and chime held for random durations.
    for (int seg_i = 0; seg_i < 30; seg_i++) begin
      bus.hours    = 8'($urandom_range(0, 9) == 0 ? $urandom_range(100, 255) : $urandom_range(0, 23));
      bus.minutes  = 8'($urandom_range(0, 9) == 0 ? $urandom_range(100, 255) : $urandom_range(0, 59));
      bus.seconds  = 8'($urandom_range(0, 99));
      bus.adj_mode = 2'($urandom_range(0, 3));
      bus.chime    = 1'($urandom_range(0, 1));
      steps($urandom_range(20, 150));
      if (seg_i == 15) begin
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed eight-digit seven-segment driver for the digital clock. It reads the time fields, adjustment mode and chime flag produced by the clock counter and shows HH-MM-SS on a common-anode display. The field being adjusted blinks, and the two separator dashes blink while the chime is active. It sits between the clock counter and the board's segment and anode pins, and runs on the fast system clock.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000 — system clock frequency in Hz.
- `SCAN_HZ`, 1000 — digit-advance rate in Hz. `SCAN_DIV = CLK_FREQ/SCAN_HZ` must be ≥ 2.
- `BLINK_HZ`, 2 — blink rate in Hz. `BLINK_HALF = CLK_FREQ/(2*BLINK_HZ)` must be ≥ 2.

Ports:
- `clk` in 1 — system clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `hours` in 8 — binary hours, expected 0–23.
- `minutes` in 8 — binary minutes, expected 0–59.
- `seconds` in 8 — binary seconds, expected 0–59.
- `adj_mode` in 2 — 0 = run, 1 = adjusting hours, 2 = adjusting minutes, 3 = treated as 0.
- `chime` in 1 — hourly chime active.
- `seg` out 8 — active-low segments. `seg[6:0]` = g,f,e,d,c,b,a; `seg[7]` = dp (always 1).
- `an` out 8 — active-low digit enables, one-hot-low. `an[7]` is the leftmost digit.

## Operation
- **Digit map**, index 7→0:
  - 7 = H tens, 6 = H units, 5 = dash
  - 4 = M tens, 3 = M units, 2 = dash
  - 1 = S tens, 0 = S units
- **Prescaler** `scan_cnt` counts 0..SCAN_DIV-1. When it equals SCAN_DIV-1 it reloads 0 and the digit index (3 bits) decrements, wrapping 0→7.
- **Snapshot registers** `snap_h`, `snap_m`, `snap_s`, `snap_mode`, `snap_chime`:
  - Load from the inputs on the edge where the index wraps 0→7.
  - The whole frame therefore displays one consistent sample, with no tearing.
  - Inputs changing mid-frame have no visible effect until the next wrap.
- **BCD conversion** of each snapshot value v:
  - tens = v/10, units = v%10, for v ≤ 99.
  - v ≥ 100 shows two dashes in that field.
- **Glyphs**, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111, blank = 1111111
- **Blink** counter `blk_cnt` counts 0..BLINK_HALF-1. On terminal count `blink_on` toggles.
- **Blanking rules** (blanked digits show `seg` = 8'hFF with `an` still enabled):
  - `snap_mode` = 1 and `blink_on` = 0 → digits 7 and 6 blank.
  - `snap_mode` = 2 and `blink_on` = 0 → digits 4 and 3 blank.
  - `snap_chime` = 1 and `blink_on` = 0 → digits 5 and 2 blank.
  - Rules combine independently.
- **No scan states** beyond the index counter; the display free-runs continuously.

## Timing
- **Reset values:**
  - `seg` = 8'hFF, `an` = 8'hFF
  - index = 7, `scan_cnt` = 0, `blk_cnt` = 0, `blink_on` = 1
  - all snapshots = 0
- **Output registers:** `seg` and `an` are registered every cycle from (index, snapshots, `blink_on`), so they lag the index by exactly 1 cycle. Both update on the same edge; there is no overlap or ghost cycle.
- **First cycle after reset:** the first edge with `rst` low drives `an` = 8'h7F with the snapshot-0 glyph (1000000).
- **Dwell:** each digit is held SCAN_DIV cycles, so a full frame is 8·SCAN_DIV cycles.
- **Snapshot latency:** an input change is visible at most 8·SCAN_DIV + 1 cycles later.
- **Blink period:** 2·BLINK_HALF cycles. Blink is not frame-aligned, so a digit may change blink state mid-dwell.
- **Reset mid-frame:** `rst` asserted on any cycle forces the reset values on that edge, overriding any scan or snapshot update.

## Test plan
Bench parameters: CLK_FREQ = 80, SCAN_HZ = 10, BLINK_HZ = 1, giving SCAN_DIV = 8 and BLINK_HALF = 40.
- **Reset:** hold `rst` for 3 cycles → `seg` = FF, `an` = FF. Release → next edge `an` = 7F, `seg` = C0. After 8 cycles `an` = BF.
- **Normal frame:** inputs 23:59:48, `adj_mode` = 0, chime = 0. Wait for the wrap, then sample one frame → `an` sequence 7F,BF,DF,EF,F7,FB,FD,FE with `seg[6:0]` 0100100, 0110000, 0111111, 0010010, 0010000, 0111111, 0011001, 0000000.
- **Anti-tear:** change `minutes` from 12 to 34 while `an` = DF → the rest of that frame shows 1/2; the next frame shows 3/4.
- **Hour adjust blink:** `adj_mode` = 1 → digits 7 and 6 show FF for 40-cycle windows alternating with glyphs, and the minute digits are never blank. With `adj_mode` = 2, digits 4 and 3 blink instead.
- **Chime:** chime = 1 → digits 5 and 2 alternate dash/blank every 40 cycles; time digits are unaffected.
- **Out-of-range:** `hours` = 150 → digits 7 and 6 show dash. `adj_mode` = 3 → no blinking.
